fht_io_ctrl: RTL and testbench



---
 rtl/fht_io_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fht_io_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fht_io_ctrl.sv
// fht_io_ctrl: loads a serial frame into the 4-bank FHT core, starts it and
// streams the result back. Ports: iCLK/iRESET; iVALID/iDATA/oREADY input
// stream; oWE/oADDR_WR/oDATA_WR core load port; oSTART/iFHT_RDY core control;
// oADDR_RD/iRAM_0..3 core read port; oVALID/oDATA/oLAST/iREADY output
// stream; oBUSY/oDONE/oERR status.
module fht_io_ctrl #(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iVALID,
  input  logic [D_BIT-1:0] iDATA,
  output logic             oREADY,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic             oSTART,
  input  logic             iFHT_RDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iRAM_0,
  input  logic [D_BIT-1:0] iRAM_1,
  input  logic [D_BIT-1:0] iRAM_2,
  input  logic [D_BIT-1:0] iRAM_3,
  output logic             oVALID,
  output logic [D_BIT-1:0] oDATA,
  output logic             oLAST,
  input  logic             iREADY,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT, S_RD, S_RDW, S_DRAIN
  } state_t;

  localparam int K_BIT = A_BIT + 2;
  localparam logic [A_BIT-1:0] A_LAST = '1;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);
  localparam logic [2:0] LAT_LIM = 3'(RD_LAT - 1);

  state_t state, state_nx;

  logic [K_BIT-1:0] k;
  logic [A_BIT-1:0] a;
  logic [1:0]       b;
  logic [2:0]       lat_cnt;
  logic [31:0]      to_cnt;
  logic             fht_prev;
  logic [D_BIT-1:0] rd_buf [4];

  logic [3:0]       we;
  logic [A_BIT-1:0] addr_wr;
  logic [D_BIT-1:0] data_wr;
  logic [A_BIT-1:0] addr_rd;
  logic             done;
  logic             err;

  logic in_hs, out_hs, fht_rise, to_hit, lat_done;

  assign in_hs    = iVALID && (state == S_LOAD);
  assign out_hs   = iREADY && (state == S_DRAIN);
  assign fht_rise = iFHT_RDY && !fht_prev;
  assign to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LIM);
  assign lat_done = (lat_cnt == LAT_LIM);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:  if (in_hs && (k == '1)) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (fht_rise)    state_nx = S_RD;
        else if (to_hit) state_nx = S_LOAD;
      end
      S_RD:    state_nx = S_RDW;
      S_RDW:   if (lat_done) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (out_hs && (b == 2'd3))
          state_nx = (a == A_LAST) ? S_LOAD : S_RD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= S_LOAD;
      k        <= '0;
      a        <= '0;
      b        <= '0;
      lat_cnt  <= '0;
      to_cnt   <= '0;
      fht_prev <= 1'b0;
      we       <= '0;
      addr_wr  <= '0;
      data_wr  <= '0;
      addr_rd  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < 4; i++) rd_buf[i] <= '0;
    end else begin
      state    <= state_nx;
      we       <= '0;
      done     <= 1'b0;
      // Sampled every cycle so the START cycle leaves the current
      // level in place; a level already high then cannot qualify.
      fht_prev <= iFHT_RDY;
      if (in_hs) begin
        we      <= 4'b0001 << k[1:0];
        addr_wr <= k[K_BIT-1:2];
        data_wr <= iDATA;
        k       <= k + K_BIT'(1);
        err     <= 1'b0;
      end
      if (state == S_START) to_cnt <= '0;
      if (state == S_WAIT) begin
        to_cnt <= to_cnt + 32'd1;
        if (fht_rise) begin
          a       <= '0;
          addr_rd <= '0;
        end else if (to_hit) begin
          err <= 1'b1;
          k   <= '0;
        end
      end
      if (state == S_RD) lat_cnt <= '0;
      if (state == S_RDW) begin
        lat_cnt <= lat_cnt + 3'd1;
        if (lat_done) begin
          rd_buf[0] <= iRAM_0;
          rd_buf[1] <= iRAM_1;
          rd_buf[2] <= iRAM_2;
          rd_buf[3] <= iRAM_3;
          b         <= '0;
        end
      end
      if (out_hs) begin
        b <= b + 2'd1;
        if (b == 2'd3) begin
          if (a == A_LAST) begin
            done <= 1'b1;
            k    <= '0;
          end else begin
            a       <= a + A_BIT'(1);
            addr_rd <= a + A_BIT'(1);
          end
        end
      end
    end
  end

  assign oREADY   = (state == S_LOAD);
  assign oSTART   = (state == S_START);
  assign oWE      = we;
  assign oADDR_WR = addr_wr;
  assign oDATA_WR = data_wr;
  assign oADDR_RD = addr_rd;
  assign oVALID   = (state == S_DRAIN);
  assign oDATA    = rd_buf[b];
  assign oLAST    = oVALID && (a == A_LAST) && (b == 2'd3);
  assign oBUSY    = (state != S_LOAD) || (k != '0);
  assign oDONE    = done;
  assign oERR     = err;

endmodule

// File: tb/tb_fht_io_ctrl.sv
// tb_fht_io_ctrl: random-stimulus bench for fht_io_ctrl with a simple
// 4-bank core model and a frame-level reference of the expected stream.
module tb_fht_io_ctrl;

  localparam int DB = 16;
  localparam int AB = 2;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ivalid, oready, ostart, fht_rdy;
  logic [DB-1:0] idata, odata_wr, odata;
  logic [3:0]    owe;
  logic [AB-1:0] oaddr_wr, oaddr_rd;
  logic [DB-1:0] ram [4];
  logic          ovalid, olast, iready, obusy, odone, oerr;

  logic          t_valid, t_oready, t_start, t_fht;
  logic [DB-1:0] t_data, t_dwr, t_odata, zero16;
  logic [3:0]    t_owe;
  logic [AB-1:0] t_awr, t_ard;
  logic          t_ovalid, t_olast, t_iready, t_busy, t_done, t_err;

  fht_io_ctrl #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(1), .TIMEOUT(200)) dut (
    .iCLK(clk), .iRESET(rst),
    .iVALID(ivalid), .iDATA(idata), .oREADY(oready),
    .oWE(owe), .oADDR_WR(oaddr_wr), .oDATA_WR(odata_wr),
    .oSTART(ostart), .iFHT_RDY(fht_rdy), .oADDR_RD(oaddr_rd),
    .iRAM_0(ram[0]), .iRAM_1(ram[1]), .iRAM_2(ram[2]), .iRAM_3(ram[3]),
    .oVALID(ovalid), .oDATA(odata), .oLAST(olast), .iREADY(iready),
    .oBUSY(obusy), .oDONE(odone), .oERR(oerr)
  );

  fht_io_ctrl #(.D_BIT(DB), .A_BIT(AB), .RD_LAT(1), .TIMEOUT(20)) dut_to (
    .iCLK(clk), .iRESET(rst),
    .iVALID(t_valid), .iDATA(t_data), .oREADY(t_oready),
    .oWE(t_owe), .oADDR_WR(t_awr), .oDATA_WR(t_dwr),
    .oSTART(t_start), .iFHT_RDY(t_fht), .oADDR_RD(t_ard),
    .iRAM_0(zero16), .iRAM_1(zero16), .iRAM_2(zero16), .iRAM_3(zero16),
    .oVALID(t_ovalid), .oDATA(t_odata), .oLAST(t_olast), .iREADY(t_iready),
    .oBUSY(t_busy), .oDONE(t_done), .oERR(t_err)
  );

  // Core model: mode 0 returns 100*addr+bank, mode 1 returns what was loaded.
  logic [DB-1:0] mem [4][4];
  bit mode;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (owe[i]) mem[i][oaddr_wr] <= odata_wr;
      ram[i] <= mode ? mem[i][oaddr_rd] : DB'(100 * oaddr_rd + i);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DB-1:0] frame [N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctl"}, 32'({oready, owe, oaddr_wr, ostart, oaddr_rd,
                            ovalid, olast, obusy, odone, oerr}), 32'h4000);
    chk({tag, "_dwr"}, 32'(odata_wr), 0);
    chk({tag, "_dout"}, 32'(odata), 0);
  endtask

  task automatic load_frame(input bit ramp, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ivalid = 1'b0;
        @(negedge clk);
        chk("we_idle", 32'(owe), 0);
      end
      idata = ramp ? DB'(k) : DB'($urandom);
      frame[k] = idata;
      ivalid = 1'b1;
      chk("ready", 32'(oready), 1);
      @(negedge clk);
      ivalid = 1'b0;
      chk("we", 32'(owe), 32'(1 << (k % 4)));
      chk("addr_wr", 32'(oaddr_wr), 32'(k / 4));
      chk("data_wr", 32'(odata_wr), 32'(frame[k]));
      chk("start", 32'(ostart), 32'(k == N - 1));
    end
  endtask

  task automatic wait_phase(input int dly, input bit held);
    if (held) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("held_quiet", 32'({ostart, ovalid, oready, obusy}), 32'b0001);
      end
      fht_rdy = 1'b0;
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_quiet", 32'({ostart, ovalid, oready, obusy}), 32'b0001);
    end
    fht_rdy = 1'b1;
    @(negedge clk);
    chk("addr_rd0", 32'(oaddr_rd), 0);
    chk("rd_quiet", 32'(ovalid), 0);
    @(negedge clk);
    chk("rdw_quiet", 32'(ovalid), 0);
    @(negedge clk);
    chk("first_valid", 32'(ovalid), 1);
  endtask

  task automatic unload(input bit stall, input int abort_at);
    int got = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [DB-1:0] held_d = '0;
    logic [DB-1:0] exp_d;
    while (got < N && cyc < 1000) begin
      iready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (got == abort_at && ovalid) begin
        iready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fht_rdy = 1'b0;
        iready = 1'b1;
        chk_reset_state("abort");
        return;
      end
      chk("done_low", 32'(odone), 0);
      if (held) chk("hold_valid", 32'(ovalid), 1);
      if (ovalid) begin
        exp_d = mode ? frame[got] : DB'(100 * (got / 4) + got % 4);
        chk("odata", 32'(odata), 32'(exp_d));
        chk("olast", 32'(olast), 32'(got == N - 1));
        if (held) chk("hold_data", 32'(odata), 32'(held_d));
        held = !iready;
        held_d = odata;
        if (iready) got++;
      end
      @(negedge clk);
      cyc++;
    end
    iready = 1'b1;
    chk("unload_count", 32'(got), 32'(N));
    chk("done", 32'({odone, oready, ovalid, obusy}), 32'b1100);
    fht_rdy = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(odone), 0);
  endtask

  initial begin
    ivalid = 1'b0; idata = '0; fht_rdy = 1'b0; iready = 1'b1; mode = 1'b0;
    t_valid = 1'b0; t_data = '0; t_fht = 1'b0; t_iready = 1'b1;
    zero16 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");
    chk("t_reset", 32'({t_err, t_oready, t_busy}), 32'b010);

    mode = 1'b0;
    load_frame(1'b1, 1'b0);
    wait_phase(50, 1'b0);
    unload(1'b0, -1);

    mode = 1'b1;
    load_frame(1'b0, 1'b1);
    wait_phase($urandom_range(5, 60), 1'b0);
    unload(1'b1, -1);

    fht_rdy = 1'b1;
    load_frame(1'b0, 1'b0);
    wait_phase(3, 1'b1);
    unload(1'b0, -1);

    mode = 1'b0;
    load_frame(1'b0, 1'b0);
    wait_phase(20, 1'b0);
    unload(1'b0, 6);

    mode = 1'b1;
    load_frame(1'b0, 1'b1);
    wait_phase(10, 1'b0);
    unload(1'b1, -1);

    for (int k = 0; k < N; k++) begin
      t_valid = 1'b1;
      t_data = DB'($urandom);
      @(negedge clk);
    end
    t_valid = 1'b0;
    chk("t_start", 32'(t_start), 1);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i <= 20)
        chk("t_wait", 32'({t_err, t_oready, t_busy}), 32'b001);
      else
        chk("t_err", 32'({t_err, t_oready, t_busy}), 32'b110);
    end
    @(negedge clk);
    chk("t_err_sticky", 32'(t_err), 1);
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    chk("t_err_clr", 32'({t_err, t_busy}), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
